// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache (one word per line).
// Optional load hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wt #(
   parameter int unsigned INDEX_W = 10,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_oe,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_we,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_valid,
   output logic              cpu_ready,
   output logic              dram_oe,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [31:0]       dram_wdata,
   output logic [3:0]        dram_we,
   input  logic [31:0]       dram_rdata,
   input  logic              dram_valid,
   input  logic              dram_busy,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int unsigned LINES = 1 << INDEX_W;
   localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_REQ  = 2'd1;
   localparam logic [1:0] RD_WAIT = 2'd2;
   localparam logic [1:0] WR_REQ  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        we_q, we_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic [LINES-1:0]  valid_q, valid_d;

   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [LINES];

   logic [INDEX_W-1:0] idx, fill_idx, line_idx;
   logic [TAG_W-1:0]   req_tag, fill_tag, line_tag;
   logic [31:0]        line_rd, merged, line_data;
   logic               hit, accept, is_store, line_we;
   logic               unused_addr_bits;

   assign idx      = cpu_addr[INDEX_W+1:2];
   assign req_tag  = cpu_addr[ADDR_W-1:INDEX_W+2];
   assign fill_idx = addr_q[INDEX_W+1:2];
   assign fill_tag = addr_q[ADDR_W-1:INDEX_W+2];
   assign line_rd  = data_q[idx];
   assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
   assign is_store = |cpu_we;
   assign accept   = cpu_oe && cpu_ready;

   assign unused_addr_bits = ^cpu_addr[1:0];

   assign cpu_ready  = resetn && (state_q == IDLE);
   assign cpu_valid  = cpu_valid_q;
   assign cpu_rdata  = rdata_q;
   assign dram_oe    = (state_q == RD_REQ) || (state_q == WR_REQ);
   assign dram_addr  = addr_q;
   assign dram_wdata = wdata_q;
   assign dram_we    = (state_q == WR_REQ) ? we_q : 4'b0000;

   always_comb begin
      merged = line_rd;
      for (int unsigned b = 0; b < 4; b++) begin
         if (cpu_we[b]) merged[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      rdata_d     = rdata_q;
      cpu_valid_d = 1'b0;
      valid_d     = valid_q;
      line_we     = 1'b0;
      line_idx    = idx;
      line_tag    = req_tag;
      line_data   = merged;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_store) begin
                  addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                  wdata_d = cpu_wdata;
                  we_d    = cpu_we;
                  state_d = WR_REQ;
                  // Write-through: a store hit updates the line now, a miss leaves it alone.
                  line_we = hit;
               end else if (hit) begin
                  rdata_d     = line_rd;
                  cpu_valid_d = 1'b1;
               end else begin
                  addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                  state_d = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (!dram_busy) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (dram_valid) begin
               line_we           = 1'b1;
               line_idx          = fill_idx;
               line_tag          = fill_tag;
               line_data         = dram_rdata;
               valid_d[fill_idx] = 1'b1;
               rdata_d           = dram_rdata;
               cpu_valid_d       = 1'b1;
               state_d           = IDLE;
            end
         end
         WR_REQ: begin
            if (!dram_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= '0;
         rdata_q     <= '0;
         cpu_valid_q <= 1'b0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         rdata_q     <= rdata_d;
         cpu_valid_q <= cpu_valid_d;
         valid_q     <= valid_d;
      end
   end

   // Tag/data storage carries no reset; line validity lives in valid_q.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[line_idx]  <= line_tag;
         data_q[line_idx] <= line_data;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        ld_acc;

   assign ld_acc = accept && !is_store;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (ld_acc && hit)  hit_cnt_d  = hit_cnt_q + 32'd1;
      if (ld_acc && !hit) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: expected load data is queued when a load is
// driven and compared when cpu_valid appears; DRAM is played by the bench tasks.
module tb_dcache_wt;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        cpu_oe;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_we;
   logic [31:0] cpu_rdata;
   logic        cpu_valid;
   logic        cpu_ready;
   logic        dram_oe;
   logic [31:0] dram_addr;
   logic [31:0] dram_wdata;
   logic [3:0]  dram_we;
   logic [31:0] dram_rdata;
   logic        dram_valid;
   logic        dram_busy;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   int          exp_hits = 0;
   int          exp_misses = 0;
   logic [31:0] sb_q [$];

   dcache_wt #(.INDEX_W(10), .ADDR_W(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cpu_oe     (cpu_oe),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_rdata  (cpu_rdata),
      .cpu_valid  (cpu_valid),
      .cpu_ready  (cpu_ready),
      .dram_oe    (dram_oe),
      .dram_addr  (dram_addr),
      .dram_wdata (dram_wdata),
      .dram_we    (dram_we),
      .dram_rdata (dram_rdata),
      .dram_valid (dram_valid),
      .dram_busy  (dram_busy),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cpu_valid) begin
         if (sb_q.size() == 0) chk("unexp_valid", 32'(cpu_valid), 32'd0);
         else                  chk("rdata", cpu_rdata, sb_q.pop_front());
      end
   end

   task automatic chk_cnt();
`ifdef DCACHE_STATS_EN
      chk("hit_cnt", hit_cnt, 32'(exp_hits));
      chk("miss_cnt", miss_cnt, 32'(exp_misses));
`else
      chk("hit_cnt", hit_cnt, 32'd0);
      chk("miss_cnt", miss_cnt, 32'd0);
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cpu_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready", 32'(cpu_ready), 32'd1);
   endtask

   task automatic cpu_load(input logic [31:0] addr, input logic [31:0] data,
                           input bit miss, input int busy);
      wait_ready();
      cpu_oe   = 1'b1;
      cpu_addr = addr;
      cpu_we   = 4'b0000;
      sb_q.push_back(data);
      if (miss) exp_misses++;
      else      exp_hits++;
      @(negedge clk);
      cpu_oe = 1'b0;
      if (!miss) begin
         chk("hit_valid", 32'(cpu_valid), 32'd1);
         chk("hit_no_dram", 32'(dram_oe), 32'd0);
         @(negedge clk);
         chk("hit_pulse", 32'(cpu_valid), 32'd0);
      end else begin
         chk("rd_oe", 32'(dram_oe), 32'd1);
         chk("rd_addr", dram_addr, addr & ~32'h3);
         chk("rd_we", 32'(dram_we), 32'd0);
         chk("rd_ready", 32'(cpu_ready), 32'd0);
         if (busy > 0) begin
            dram_busy = 1'b1;
            for (int j = 0; j < busy; j++) begin
               // Held CPU request and stray read data must both be ignored here.
               cpu_oe     = 1'b1;
               cpu_addr   = 32'h0000_2000;
               dram_valid = 1'b1;
               dram_rdata = 32'hDEAD_BEEF;
               @(negedge clk);
               chk("busy_oe", 32'(dram_oe), 32'd1);
               chk("busy_addr", dram_addr, addr & ~32'h3);
               chk("busy_ready", 32'(cpu_ready), 32'd0);
            end
            dram_busy  = 1'b0;
            cpu_oe     = 1'b0;
            dram_valid = 1'b0;
         end
         @(negedge clk);
         chk("rd_oe_drop", 32'(dram_oe), 32'd0);
         chk("rdwait_ready", 32'(cpu_ready), 32'd0);
         repeat (2) @(negedge clk);
         dram_valid = 1'b1;
         dram_rdata = data;
         @(negedge clk);
         dram_valid = 1'b0;
         dram_rdata = 32'h0;
         chk("miss_valid", 32'(cpu_valid), 32'd1);
         @(negedge clk);
         chk("miss_pulse", 32'(cpu_valid), 32'd0);
         chk("miss_ready", 32'(cpu_ready), 32'd1);
      end
   endtask

   task automatic cpu_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
      wait_ready();
      cpu_oe    = 1'b1;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_we    = we;
      @(negedge clk);
      cpu_oe = 1'b0;
      cpu_we = 4'b0000;
      chk("st_oe", 32'(dram_oe), 32'd1);
      chk("st_we", 32'(dram_we), 32'(we));
      chk("st_wdata", dram_wdata, wdata);
      chk("st_addr", dram_addr, addr & ~32'h3);
      chk("st_ready", 32'(cpu_ready), 32'd0);
      @(negedge clk);
      chk("st_oe_drop", 32'(dram_oe), 32'd0);
      chk("st_idle", 32'(cpu_ready), 32'd1);
      chk("st_no_valid", 32'(cpu_valid), 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_valid", 32'(cpu_valid), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_oe", 32'(dram_oe), 32'd0);
      chk("rst_addr", dram_addr, 32'd0);
      chk("rst_wdata", dram_wdata, 32'd0);
      chk("rst_we", 32'(dram_we), 32'd0);
      chk_cnt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cpu_oe     = 1'b0;
      cpu_addr   = 32'h0;
      cpu_wdata  = 32'h0;
      cpu_we     = 4'b0000;
      dram_rdata = 32'h0;
      dram_valid = 1'b0;
      dram_busy  = 1'b0;
      #1 resetn  = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      resetn = 1'b1;
      @(negedge clk);

      // Cold miss, then hits including four back-to-back.
      cpu_load(32'h0000_0100, 32'h1234_5678, 1'b1, 0);
      cpu_load(32'h0000_0100, 32'h1234_5678, 1'b0, 0);
      wait_ready();
      cpu_oe   = 1'b1;
      cpu_addr = 32'h0000_0100;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(32'h1234_5678);
         exp_hits++;
         @(negedge clk);
         chk("b2b_valid", 32'(cpu_valid), 32'd1);
         chk("b2b_no_dram", 32'(dram_oe), 32'd0);
      end
      cpu_oe = 1'b0;
      @(negedge clk);
      chk("b2b_end", 32'(cpu_valid), 32'd0);

      // Store hit merges enabled bytes; store miss does not allocate.
      cpu_store(32'h0000_0100, 32'hAABB_CCDD, 4'b0011);
      cpu_load(32'h0000_0100, 32'h1234_CCDD, 1'b0, 0);
      cpu_store(32'h0000_0100, 32'h9988_7766, 4'b1100);
      cpu_load(32'h0000_0100, 32'h9988_CCDD, 1'b0, 0);
      cpu_store(32'h0000_0204, 32'h1111_1111, 4'b1111);
      cpu_load(32'h0000_0204, 32'h5555_5555, 1'b1, 0);

      // Same index, different tag: mutual eviction.
      cpu_load(32'h0000_1100, 32'hCAFE_F00D, 1'b1, 0);
      cpu_load(32'h0000_1100, 32'hCAFE_F00D, 1'b0, 0);
      cpu_load(32'h0000_0100, 32'h0BAD_F00D, 1'b1, 0);

      // Long DRAM busy during the read request; byte offset bits ignored.
      cpu_load(32'h0000_03F8, 32'h600D_CAFE, 1'b1, 7);
      cpu_load(32'h0000_03F8, 32'h600D_CAFE, 1'b0, 0);
      cpu_load(32'h0000_03FB, 32'h600D_CAFE, 1'b0, 0);
      chk_cnt();

      // Reset while waiting for refill data; late data must be dropped.
      wait_ready();
      cpu_oe   = 1'b1;
      cpu_addr = 32'h0000_0500;
      @(negedge clk);
      cpu_oe = 1'b0;
      chk("t6_oe", 32'(dram_oe), 32'd1);
      @(negedge clk);
      chk("t6_rdwait", 32'(dram_oe), 32'd0);
      resetn     = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
      @(negedge clk);
      chk_reset_outputs();
      resetn = 1'b1;
      @(negedge clk);
      dram_valid = 1'b1;
      dram_rdata = 32'h7777_7777;
      @(negedge clk);
      dram_valid = 1'b0;
      chk("late_valid", 32'(cpu_valid), 32'd0);
      @(negedge clk);
      chk("late_valid2", 32'(cpu_valid), 32'd0);
      cpu_load(32'h0000_0100, 32'h1234_5678, 1'b1, 0);
      chk_cnt();

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
